// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding selects and mult/div sequencing
// for the 5-stage core.
//
// Inputs : register numbers and control bits of the DEC, EXE, MEM and WB
//          instructions, plus the EXE mult/div start and the DEC branch
//          decision (pcsrc_DEC).
// Outputs: stall_FET/stall_DEC, flush_DEC/flush_EXE,
//          fwdA/B_EXE (00 regfile, 01 WB, 10 MEM), fwdA/B_DEC,
//          md_busy/md_done, stall_cnt/flush_cnt.
//
// Build option: define HAZARD_PERF_EN to build the saturating stall and
// flush counters. Without it both counter ports read 0.
module hazard_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs_DEC,
    input  logic [4:0]        rt_DEC,
    input  logic              branch_DEC,
    input  logic              md_use_DEC,
    input  logic              pcsrc_DEC,
    input  logic [4:0]        rs_EXE,
    input  logic [4:0]        rt_EXE,
    input  logic [4:0]        writereg_EXE,
    input  logic              regwrite_EXE,
    input  logic              memtoreg_EXE,
    input  logic              md_start_EXE,
    input  logic [4:0]        writereg_MEM,
    input  logic              regwrite_MEM,
    input  logic              memtoreg_MEM,
    input  logic [4:0]        writereg_WB,
    input  logic              regwrite_WB,
    output logic              stall_FET,
    output logic              stall_DEC,
    output logic              flush_DEC,
    output logic              flush_EXE,
    output logic [1:0]        fwdA_EXE,
    output logic [1:0]        fwdB_EXE,
    output logic              fwdA_DEC,
    output logic              fwdB_DEC,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    md_state_t  state;
    logic [3:0] cnt;

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;
    logic flush;

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic hit(input logic [4:0] wr,
                                 input logic [4:0] src);
        return (wr != 5'd0) && (wr == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (regwrite_MEM && hit(writereg_MEM, src))
            sel = 2'b10;
        else if (regwrite_WB && hit(writereg_WB, src))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        lwstall = memtoreg_EXE &&
                  (hit(writereg_EXE, rs_DEC) ||
                   hit(writereg_EXE, rt_DEC));
        brstall = branch_DEC &&
                  ((regwrite_EXE &&
                    (hit(writereg_EXE, rs_DEC) ||
                     hit(writereg_EXE, rt_DEC))) ||
                   (memtoreg_MEM &&
                    (hit(writereg_MEM, rs_DEC) ||
                     hit(writereg_MEM, rt_DEC))));
        mdstall = md_use_DEC && (md_start_EXE || (state != IDLE));
        // Outputs are forced low while reset is held.
        stall = !reset && (lwstall || brstall || mdstall);
        // A stalled branch re-resolves next cycle, so no flush yet.
        flush = !reset && pcsrc_DEC && !stall;
    end

    always_comb begin
        stall_FET = stall;
        stall_DEC = stall;
        flush_EXE = stall;
        flush_DEC = flush;
        fwdA_EXE  = 2'b00;
        fwdB_EXE  = 2'b00;
        fwdA_DEC  = 1'b0;
        fwdB_DEC  = 1'b0;
        if (!reset) begin
            fwdA_EXE = fwd_sel(rs_EXE);
            fwdB_EXE = fwd_sel(rt_EXE);
            fwdA_DEC = regwrite_MEM && hit(writereg_MEM, rs_DEC);
            fwdB_DEC = regwrite_MEM && hit(writereg_MEM, rt_DEC);
        end
    end

    // Mult/div sequencer. Starts outside IDLE are dropped; mdstall keeps
    // a second mult/div from ever reaching EXE while one is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md_start_EXE) begin
                        state   <= BUSY;
                        cnt     <= 4'(MD_LATENCY - 1);
                        md_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state   <= DONE;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
